prbs_seq_ctrl: RTL and testbench
================================

// Module: prbs_seq_ctrl
// PURPOSE
//  Run-level sequencer for the PRBS-15 pattern core. Collects four host bytes over valid/ready,
//  resets the core, feeds the bytes on 4 consecutive cycles, times the N x 32-bit serial
//  phase, then the PRBS scramble phase for a programmed byte count. Qualifies the core's
//  serial and random outputs with valid strobes for the downstream sequence detector.
// PARAMETERS
//  LEN_W        16    width of scramble-length config/counter
//  WDOG_CYCLES  1024  max idle cycles waiting for a host byte (only with PRBS_CTRL_WDOG_EN)
// PORTS
//  clk           in   1      single clock, rising edge
//  rst           in   1      asynchronous, active-high reset
//  start         in   1      begin run; sampled only in IDLE
//  abort         in   1      stop current run, return to IDLE
//  cfg_n         in   3      serial repeat count, latched at start
//  cfg_rand_len  in   LEN_W  scramble bytes, latched at start
//  s_data        in   8      host pattern byte
//  s_valid       in   1      host byte valid
//  s_ready       out  1      byte accepted when s_valid & s_ready
//  core_rst_n    out  1      registered active-low reset to PRBS core
//  core_n        out  3      latched cfg_n to core
//  core_data_in  out  8      byte fed to core
//  core_data_out in   1      core serial bit
//  core_data_rnd in   8      core random byte
//  ser_bit/ser_valid   out 1/1   serial bit and qualifier
//  rnd_byte/rnd_valid  out 8/1   random byte and qualifier
//  busy          out  1      high in any state but IDLE
//  done          out  1      1-cycle pulse at normal run completion
//  err           out  1      sticky watchdog error, cleared by next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; core_rst_n=0, s_ready=0, ser_valid=0, rnd_valid=0, busy=0, done=0,
//   err=0, core_data_in=0, core_n=0, all counters/buffers=0.
//  FSM: IDLE -> LOAD -> ARM -> FEED -> SERIAL -> SCRAMBLE -> DONE -> IDLE.
//  IDLE: core_rst_n=0. start=1 latches cfg_n/cfg_rand_len, clears err -> LOAD.
//  LOAD: s_ready=1; bytes 0..3 stored into buf[0..3] in arrival order; after the 4th -> ARM.
//   s_ready drops the cycle after byte 3 is accepted; never accepts a 5th byte.
//  ARM: 1 cycle; core_rst_n driven 1 (stays 1 until run end/abort).
//  FEED: 4 cycles; core_data_in=buf[k] on cycle k (k=0..3); then SERIAL if core_n!=0,
//   else SCRAMBLE if rand_len!=0, else DONE.
//  SERIAL: exactly 32*core_n cycles (counter 8 bits, no wrap at n=7: 224).
//   ser_valid=1 on the cycle after each SERIAL edge (core output is registered), i.e.
//   32*n pulses total; ser_bit=core_data_out. First valid bit = buf[0][7].
//  SCRAMBLE: exactly rand_len cycles; rnd_valid delayed 1 cycle same way; rnd_byte=core_data_rnd.
//  DONE: done=1 for 1 cycle, core_rst_n=0 -> IDLE. Core is re-reset every run.
//  abort=1 in any non-IDLE state: next state IDLE, core_rst_n=0, valids drop next cycle,
//   no done pulse; partial buffer discarded. abort has priority over all transitions.
//  start while busy ignored. start & abort same cycle in IDLE: abort wins, stay IDLE.
//  cfg_* changes after start have no effect on the current run.
// CONFIGURATION
//  PRBS_CTRL_WDOG_EN defined: in LOAD, a counter counts cycles without an accepted byte;
//   reaching WDOG_CYCLES sets err=1 and returns to IDLE (no done). Counter resets per byte.
//  Not defined: no watchdog; LOAD waits forever; err tied 0.
// TESTING
//  T1 reset mid-SERIAL: assert rst -> all outputs at reset values same cycle, IDLE after release.
//  T2 bytes A5,3C,F0,0F, cfg_n=1, len=0 -> 32 ser_valid bits = A53CF00F MSB first, then done.
//  T3 cfg_n=0, len=5 -> no ser_valid, 5 rnd_valid pulses, first rnd_byte matches core seed 0xFF.
//  T4 cfg_n=7, len=3 -> exactly 224 ser_valid then 3 rnd_valid; busy high throughout.
//  T5 s_valid gaps between bytes, abort after byte 2 -> IDLE, no done, next run loads fresh 4 bytes.
//  T6 (WDOG_EN, WDOG_CYCLES=16) start, send 1 byte, stall 16 cycles -> err=1, IDLE, core_rst_n=0.

Source files
------------

// File: rtl/prbs_seq_ctrl.sv
// prbs_seq_ctrl: run-level sequencer for the PRBS-15 pattern core.
// A run collects four host bytes, resets and arms the core, feeds it the bytes, then times a
// 32*n-cycle serial phase and a rand_len-cycle scramble phase. Serial and random outputs are
// qualified with valid strobes one cycle after each active edge, because the core output is
// registered.
// Build option: define PRBS_CTRL_WDOG_EN to enable the LOAD-phase host-byte watchdog, which
// sets the sticky err flag. Without it, LOAD waits forever and err stays 0.
module prbs_seq_ctrl #(
   parameter int unsigned LEN_W       = 16,
   parameter int unsigned WDOG_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [2:0]       cfg_n,
   input  logic [LEN_W-1:0] cfg_rand_len,
   input  logic [7:0]       s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic             core_rst_n,
   output logic [2:0]       core_n,
   output logic [7:0]       core_data_in,
   input  logic             core_data_out,
   input  logic [7:0]       core_data_rnd,
   output logic             ser_bit,
   output logic             ser_valid,
   output logic [7:0]       rnd_byte,
   output logic             rnd_valid,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StArm,
      StFeed,
      StSerial,
      StScramble,
      StDone
   } state_e;

   state_e           state_q, state_d;
   logic [7:0]       pat_q [4];
   logic [7:0]       pat_d [4];
   logic [1:0]       byte_cnt_q, byte_cnt_d;
   logic [7:0]       ser_cnt_q, ser_cnt_d;
   logic [LEN_W-1:0] rnd_cnt_q, rnd_cnt_d;
   logic [2:0]       core_n_q, core_n_d;
   logic [LEN_W-1:0] rand_len_q, rand_len_d;
   logic             core_rst_n_q, core_rst_n_d;
   logic             ser_valid_q, ser_valid_d;
   logic             rnd_valid_q, rnd_valid_d;
   logic             err_q, err_d;

   logic             accept;
   logic             wdog_trip;
   logic [7:0]       ser_last;
   logic [LEN_W-1:0] rnd_last;

   assign accept   = s_valid & s_ready;
   // 32*n fits in 8 bits for n up to 7 (224), so the terminal count never wraps.
   assign ser_last = {core_n_q, 5'd0} - 8'd1;
   assign rnd_last = rand_len_q - LEN_W'(1);

`ifdef PRBS_CTRL_WDOG_EN
   localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);

   logic [WdogW-1:0] wdog_cnt_q, wdog_cnt_d;

   // Count LOAD cycles without an accepted byte; restart on every byte and outside LOAD.
   always_comb begin
      wdog_cnt_d = '0;
      wdog_trip  = 1'b0;
      if (state_q == StLoad && !accept) begin
         if (wdog_cnt_q == WdogW'(WDOG_CYCLES - 1)) begin
            wdog_trip = 1'b1;
         end else begin
            wdog_cnt_d = wdog_cnt_q + WdogW'(1);
         end
      end
   end

   // Watchdog counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog_cnt_q <= '0;
      end else begin
         wdog_cnt_q <= wdog_cnt_d;
      end
   end
`else
   logic unused_wdog;

   assign wdog_trip   = 1'b0;
   assign unused_wdog = ^WDOG_CYCLES;
`endif

   // Run sequencing: state transitions, byte capture, phase counters and config latching.
   always_comb begin
      state_d    = state_q;
      pat_d      = pat_q;
      byte_cnt_d = byte_cnt_q;
      ser_cnt_d  = ser_cnt_q;
      rnd_cnt_d  = rnd_cnt_q;
      core_n_d   = core_n_q;
      rand_len_d = rand_len_q;
      err_d      = err_q;

      unique case (state_q)
         StIdle: begin
            // Counters start clean each run so a partially loaded buffer is discarded.
            byte_cnt_d = '0;
            ser_cnt_d  = '0;
            rnd_cnt_d  = '0;
            if (start && !abort) begin
               core_n_d   = cfg_n;
               rand_len_d = cfg_rand_len;
               err_d      = 1'b0;
               state_d    = StLoad;
            end
         end
         StLoad: begin
            if (accept) begin
               pat_d[byte_cnt_q] = s_data;
               byte_cnt_d        = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  state_d = StArm;
               end
            end else if (wdog_trip) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end
         StArm: begin
            state_d = StFeed;
         end
         StFeed: begin
            // byte_cnt wrapped to 0 after the fourth byte, so it indexes the feed directly.
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
               if (core_n_q != 3'd0) begin
                  state_d = StSerial;
               end else if (rand_len_q != '0) begin
                  state_d = StScramble;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StSerial: begin
            if (ser_cnt_q == ser_last) begin
               ser_cnt_d = '0;
               state_d   = (rand_len_q != '0) ? StScramble : StDone;
            end else begin
               ser_cnt_d = ser_cnt_q + 8'd1;
            end
         end
         StScramble: begin
            if (rnd_cnt_q == rnd_last) begin
               rnd_cnt_d = '0;
               state_d   = StDone;
            end else begin
               rnd_cnt_d = rnd_cnt_q + LEN_W'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Abort overrides every other transition, including a watchdog trip in the same cycle.
      if (abort && state_q != StIdle) begin
         state_d = StIdle;
         err_d   = err_q;
      end
   end

   // Registered core reset and output qualifiers; valids trail the active phase by one cycle.
   always_comb begin
      core_rst_n_d = state_d inside {StArm, StFeed, StSerial, StScramble};
      ser_valid_d  = (state_q == StSerial) && !abort;
      rnd_valid_d  = (state_q == StScramble) && !abort;
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         for (int i = 0; i < 4; i++) begin
            pat_q[i] <= '0;
         end
         byte_cnt_q   <= '0;
         ser_cnt_q    <= '0;
         rnd_cnt_q    <= '0;
         core_n_q     <= '0;
         rand_len_q   <= '0;
         core_rst_n_q <= 1'b0;
         ser_valid_q  <= 1'b0;
         rnd_valid_q  <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pat_q        <= pat_d;
         byte_cnt_q   <= byte_cnt_d;
         ser_cnt_q    <= ser_cnt_d;
         rnd_cnt_q    <= rnd_cnt_d;
         core_n_q     <= core_n_d;
         rand_len_q   <= rand_len_d;
         core_rst_n_q <= core_rst_n_d;
         ser_valid_q  <= ser_valid_d;
         rnd_valid_q  <= rnd_valid_d;
         err_q        <= err_d;
      end
   end

   assign s_ready      = (state_q == StLoad);
   assign busy         = (state_q != StIdle);
   assign done         = (state_q == StDone);
   assign core_rst_n   = core_rst_n_q;
   assign core_n       = core_n_q;
   assign core_data_in = (state_q == StFeed) ? pat_q[byte_cnt_q] : 8'd0;
   assign ser_bit      = core_data_out;
   assign ser_valid    = ser_valid_q;
   assign rnd_byte     = core_data_rnd;
   assign rnd_valid    = rnd_valid_q;
   assign err          = err_q;

endmodule

// File: tb/tb_prbs_seq_ctrl.sv
// Directed bench for prbs_seq_ctrl with a behavioural PRBS core stub.
// The stub latches the four fed bytes, replays them MSB first during the serial phase and
// emits a PRBS-15 low byte (seed 0x7FFF) per scramble cycle, all registered.
`timescale 1ns/1ps
module tb_prbs_seq_ctrl;
   localparam int unsigned LEN_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [2:0]       cfg_n = 3'd0;
   logic [LEN_W-1:0] cfg_rand_len = '0;
   logic [7:0]       s_data = 8'd0;
   logic             s_valid = 1'b0;
   logic             s_ready;
   logic             core_rst_n;
   logic [2:0]       core_n;
   logic [7:0]       core_data_in;
   logic             core_data_out = 1'b0;
   logic [7:0]       core_data_rnd = 8'd0;
   logic             ser_bit;
   logic             ser_valid;
   logic [7:0]       rnd_byte;
   logic             rnd_valid;
   logic             busy;
   logic             done;
   logic             err;

   int checks = 0;
   int errors = 0;

   prbs_seq_ctrl #(
      .LEN_W      (LEN_W),
      .WDOG_CYCLES(16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .cfg_n        (cfg_n),
      .cfg_rand_len (cfg_rand_len),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .core_rst_n   (core_rst_n),
      .core_n       (core_n),
      .core_data_in (core_data_in),
      .core_data_out(core_data_out),
      .core_data_rnd(core_data_rnd),
      .ser_bit      (ser_bit),
      .ser_valid    (ser_valid),
      .rnd_byte     (rnd_byte),
      .rnd_valid    (rnd_valid),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   always #5 clk = ~clk;

   // Core stub: edge 0 after reset release is ARM, edges 1..4 latch the fed bytes.
   logic [31:0] core_pat = '0;
   logic [14:0] core_lfsr = 15'h7FFF;
   int          core_cyc = 0;
   always @(posedge clk) begin
      if (core_rst_n !== 1'b1) begin
         core_cyc      <= 0;
         core_pat      <= '0;
         core_lfsr     <= 15'h7FFF;
         core_data_out <= 1'b0;
         core_data_rnd <= 8'd0;
      end else begin
         core_cyc <= core_cyc + 1;
         if (core_cyc >= 1 && core_cyc <= 4) begin
            core_pat <= {core_pat[23:0], core_data_in};
         end else if (core_cyc >= 5 && core_cyc < 5 + 32 * int'(core_n)) begin
            core_data_out <= core_pat[31 - ((core_cyc - 5) % 32)];
         end else if (core_cyc >= 5) begin
            core_data_rnd <= core_lfsr[7:0];
            core_lfsr     <= {core_lfsr[13:0], core_lfsr[14] ^ core_lfsr[13]};
         end
      end
   end

   // Output monitor, sampled on the falling edge.
   int         ser_total = 0;
   int         rnd_total = 0;
   int         done_total = 0;
   logic       ser_log [1024];
   logic [7:0] rnd_log [64];
   always @(negedge clk) begin
      if (ser_valid === 1'b1) begin
         if (ser_total < 1024) ser_log[ser_total] <= ser_bit;
         ser_total <= ser_total + 1;
      end
      if (rnd_valid === 1'b1) begin
         if (rnd_total < 64) rnd_log[rnd_total] <= rnd_byte;
         rnd_total <= rnd_total + 1;
      end
      if (done === 1'b1) done_total <= done_total + 1;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [2:0] n, input logic [LEN_W-1:0] len);
      cfg_n        = n;
      cfg_rand_len = len;
      start        = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
      ok = 1'b0;
      repeat (gap) tick();
      s_data  = b;
      s_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (s_ready === 1'b1) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
            break;
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic send4(input logic [31:0] w, input int gap, output bit ok);
      bit one;
      logic [31:0] v;
      ok = 1'b1;
      v  = w;
      for (int i = 0; i < 4; i++) begin
         send_byte(v[31:24], gap, one);
         ok = ok & one;
         v  = v << 8;
      end
   endtask

   task automatic wait_done(input int budget, output bit ok, output int busy_low);
      ok       = 1'b0;
      busy_low = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (busy !== 1'b1) busy_low++;
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      tick();
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
      checks++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL reset_core_rst_n: got %b want 0", core_rst_n); end
      checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL reset_ser_valid: got %b want 0", ser_valid); end
      checks++; if (rnd_valid !== 1'b0) begin errors++; $display("FAIL reset_rnd_valid: got %b want 0", rnd_valid); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
      checks++; if (core_data_in !== 8'h00) begin errors++; $display("FAIL reset_core_data_in: got %h want 00", core_data_in); end
      checks++; if (core_n !== 3'd0) begin errors++; $display("FAIL reset_core_n: got %0d want 0", core_n); end
      rst = 1'b0;
      tick();
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_after: busy got %b want 0", busy); end
   endtask

   task automatic test_serial();
      int s0, r0, d0, bl, bad;
      bit ok;
      logic [31:0] exp_w;
      exp_w = 32'hA53CF00F;
      s0 = ser_total; r0 = rnd_total; d0 = done_total;
      do_start(3'd1, 16'd0);
      // Config changes after start must not affect this run.
      cfg_n        = 3'd5;
      cfg_rand_len = 16'd9;
      checks++; if (core_n !== 3'd1) begin errors++; $display("FAIL serial_core_n: got %0d want 1", core_n); end
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL serial_load_ready: got %b want 1", s_ready); end
      send4(exp_w, 0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL serial_handshake: got %b want 1", ok); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL serial_ready_drop: got %b want 0", s_ready); end
      checks++; if (core_rst_n !== 1'b1) begin errors++; $display("FAIL serial_arm_core_rst_n: got %b want 1", core_rst_n); end
      wait_done(200, ok, bl);
      checks++; if (!ok) begin errors++; $display("FAIL serial_done_seen: got %b want 1", ok); end
      repeat (2) tick();
      checks++; if (ser_total - s0 != 32) begin errors++; $display("FAIL serial_count: got %0d want 32", ser_total - s0); end
      bad = 0;
      for (int i = 0; i < 32; i++) if (ser_log[s0 + i] !== exp_w[31 - i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL serial_bits: got %0d wrong bits want 0", bad); end
      checks++; if (rnd_total - r0 != 0) begin errors++; $display("FAIL serial_rnd_count: got %0d want 0", rnd_total - r0); end
      checks++; if (done_total - d0 != 1) begin errors++; $display("FAIL serial_done_count: got %0d want 1", done_total - d0); end
      checks++; if (busy !== 1'b0 || core_rst_n !== 1'b0) begin errors++; $display("FAIL serial_end_idle: busy %b core_rst_n %b want 0 0", busy, core_rst_n); end
   endtask

   task automatic test_scramble();
      int s0, r0, d0, bl, bad;
      bit ok;
      logic [7:0] exp_r [5];
      exp_r = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0};
      s0 = ser_total; r0 = rnd_total; d0 = done_total;
      do_start(3'd0, 16'd5);
      send4(32'h01020304, 0, ok);
      wait_done(200, ok, bl);
      checks++; if (!ok) begin errors++; $display("FAIL scramble_done_seen: got %b want 1", ok); end
      repeat (2) tick();
      checks++; if (ser_total - s0 != 0) begin errors++; $display("FAIL scramble_ser_count: got %0d want 0", ser_total - s0); end
      checks++; if (rnd_total - r0 != 5) begin errors++; $display("FAIL scramble_rnd_count: got %0d want 5", rnd_total - r0); end
      checks++; if (rnd_log[r0] !== 8'hFF) begin errors++; $display("FAIL scramble_first_byte: got %h want ff", rnd_log[r0]); end
      bad = 0;
      for (int i = 0; i < 5; i++) if (rnd_log[r0 + i] !== exp_r[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL scramble_bytes: got %0d wrong bytes want 0", bad); end
      checks++; if (done_total - d0 != 1) begin errors++; $display("FAIL scramble_done_count: got %0d want 1", done_total - d0); end
   endtask

   task automatic test_long();
      int s0, r0, d0, bl, bad;
      bit ok;
      logic [31:0] exp_w;
      logic [7:0]  exp_r [3];
      exp_w = 32'hDEADBEEF;
      exp_r = '{8'hFF, 8'hFE, 8'hFC};
      s0 = ser_total; r0 = rnd_total; d0 = done_total;
      do_start(3'd7, 16'd3);
      send4(exp_w, 0, ok);
      repeat (10) tick();
      // A start while busy must be ignored.
      cfg_n = 3'd2;
      cfg_rand_len = 16'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(400, ok, bl);
      checks++; if (!ok) begin errors++; $display("FAIL long_done_seen: got %b want 1", ok); end
      checks++; if (bl != 0) begin errors++; $display("FAIL long_busy: got %0d low cycles want 0", bl); end
      repeat (2) tick();
      checks++; if (ser_total - s0 != 224) begin errors++; $display("FAIL long_ser_count: got %0d want 224", ser_total - s0); end
      bad = 0;
      for (int i = 0; i < 224; i++) if (ser_log[s0 + i] !== exp_w[31 - (i % 32)]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL long_ser_bits: got %0d wrong bits want 0", bad); end
      checks++; if (rnd_total - r0 != 3) begin errors++; $display("FAIL long_rnd_count: got %0d want 3", rnd_total - r0); end
      bad = 0;
      for (int i = 0; i < 3; i++) if (rnd_log[r0 + i] !== exp_r[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL long_rnd_bytes: got %0d wrong bytes want 0", bad); end
      checks++; if (done_total - d0 != 1) begin errors++; $display("FAIL long_done_count: got %0d want 1", done_total - d0); end
      checks++; if (core_n !== 3'd7) begin errors++; $display("FAIL long_core_n: got %0d want 7", core_n); end
   endtask

   task automatic test_abort_load();
      int s0, d0, bl, bad;
      bit ok, ok2;
      logic [31:0] exp_w;
      exp_w = 32'h12345678;
      s0 = ser_total; d0 = done_total;
      do_start(3'd1, 16'd0);
      send_byte(8'h11, 2, ok);
      send_byte(8'h22, 3, ok2);
      repeat (2) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++; if (busy !== 1'b0 || s_ready !== 1'b0 || core_rst_n !== 1'b0) begin errors++; $display("FAIL abort_load_idle: busy %b s_ready %b core_rst_n %b want 0 0 0", busy, s_ready, core_rst_n); end
      repeat (5) tick();
      checks++; if (done_total - d0 != 0 || ser_total - s0 != 0) begin errors++; $display("FAIL abort_load_no_done: done %0d ser %0d want 0 0", done_total - d0, ser_total - s0); end
      do_start(3'd1, 16'd0);
      send4(exp_w, 1, ok);
      checks++; if (!(ok && ok2)) begin errors++; $display("FAIL abort_load_handshake: got %b want 1", ok && ok2); end
      wait_done(200, ok, bl);
      repeat (2) tick();
      checks++; if (ser_total - s0 != 32) begin errors++; $display("FAIL abort_fresh_count: got %0d want 32", ser_total - s0); end
      bad = 0;
      for (int i = 0; i < 32; i++) if (ser_log[s0 + i] !== exp_w[31 - i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL abort_fresh_bits: got %0d wrong bits want 0", bad); end
      checks++; if (done_total - d0 != 1) begin errors++; $display("FAIL abort_fresh_done: got %0d want 1", done_total - d0); end
   endtask

   task automatic test_abort_serial();
      int r0, d0;
      bit ok, seen;
      r0 = rnd_total; d0 = done_total;
      do_start(3'd2, 16'd4);
      send4(32'h55AA00FF, 0, ok);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ser_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      checks++; if (!seen) begin errors++; $display("FAIL abort_ser_valid_seen: got %b want 1", seen); end
      #4;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++; if (ser_valid !== 1'b0 || busy !== 1'b0 || core_rst_n !== 1'b0) begin errors++; $display("FAIL abort_ser_drop: ser_valid %b busy %b core_rst_n %b want 0 0 0", ser_valid, busy, core_rst_n); end
      repeat (80) tick();
      checks++; if (done_total - d0 != 0 || rnd_total - r0 != 0) begin errors++; $display("FAIL abort_ser_no_done: done %0d rnd %0d want 0 0", done_total - d0, rnd_total - r0); end
   endtask

   task automatic test_start_abort_idle();
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      checks++; if (busy !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL start_abort_idle: busy %b s_ready %b want 0 0", busy, s_ready); end
   endtask

`ifdef PRBS_CTRL_WDOG_EN
   task automatic test_wdog();
      int d0;
      bit ok;
      d0 = done_total;
      do_start(3'd1, 16'd0);
      send_byte(8'hAA, 0, ok);
      repeat (15) tick();
      checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wdog_early: err %b busy %b want 0 1", err, busy); end
      tick();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL wdog_err: got %b want 1", err); end
      checks++; if (busy !== 1'b0 || core_rst_n !== 1'b0) begin errors++; $display("FAIL wdog_idle: busy %b core_rst_n %b want 0 0", busy, core_rst_n); end
      checks++; if (done_total - d0 != 0) begin errors++; $display("FAIL wdog_no_done: got %0d want 0", done_total - d0); end
      repeat (3) tick();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL wdog_sticky: got %b want 1", err); end
      do_start(3'd0, 16'd0);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL wdog_clear: got %b want 0", err); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask
`else
   task automatic test_no_wdog();
      bit ok;
      do_start(3'd1, 16'd0);
      send_byte(8'hAA, 0, ok);
      repeat (40) tick();
      checks++; if (busy !== 1'b1 || s_ready !== 1'b1) begin errors++; $display("FAIL no_wdog_wait: busy %b s_ready %b want 1 1", busy, s_ready); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL no_wdog_err: got %b want 0", err); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask
`endif

   task automatic test_reset_mid();
      bit ok;
      do_start(3'd7, 16'd2);
      send4(32'hC0FFEE11, 0, ok);
      repeat (40) tick();
      checks++; if (ser_valid !== 1'b1) begin errors++; $display("FAIL reset_mid_in_serial: ser_valid %b want 1", ser_valid); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || core_rst_n !== 1'b0 || ser_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_async: busy %b core_rst_n %b ser_valid %b want 0 0 0", busy, core_rst_n, ser_valid); end
      checks++; if (core_n !== 3'd0 || s_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_mid_regs: core_n %0d s_ready %b done %b want 0 0 0", core_n, s_ready, done); end
      @(posedge clk);
      #2;
      rst = 1'b0;
      tick();
      tick();
      checks++; if (busy !== 1'b0 || core_rst_n !== 1'b0) begin errors++; $display("FAIL reset_mid_release: busy %b core_rst_n %b want 0 0", busy, core_rst_n); end
   endtask

   initial begin
      test_reset();
      test_serial();
      test_scramble();
      test_long();
      test_abort_load();
      test_abort_serial();
      test_start_abort_idle();
`ifdef PRBS_CTRL_WDOG_EN
      test_wdog();
`else
      test_no_wdog();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
